// File: rtl/dual_ram_pkg.sv
// Shared types and constants for the dual_ram port-B read streamer.
// Holds the sequencer state enum and the prefetch FIFO sizing helper.
package dual_ram_pkg;

  localparam int RD_LAT_MAX = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  function automatic int fifo_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

endpackage

// File: rtl/dual_ram_rd_fifo.sv
// Prefetch FIFO with first-word-fall-through head and occupancy count.
// Head output reads as zero while empty.
module dual_ram_rd_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pointer wrap at DEPTH (need not be a power of two) and count update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CW'(wr_en_i) - CW'(rd_en_i);
    if (wr_en_i) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (rd_en_i) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
  end

  // Pointer and count registers; reset flushes the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign valid_o   = (cnt_q != '0);
  assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o   = cnt_q;

endmodule

// File: rtl/dual_ram_rd_stream.sv
// Port-B read sequencer: streams len words from base as valid/ready.
// Define DUAL_RAM_RD_PARITY_EN to add the o_tpar even-parity output.
module dual_ram_rd_stream
  import dual_ram_pkg::*;
#(
  parameter int AW     = 5,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [AW-1:0] i_base_addr,
  input  logic [AW:0]   i_len,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_addr_b,
  output logic          o_wr_en_b,
  output logic [DW-1:0] o_wrdata_b,
  input  logic [DW-1:0] i_rddata_b,
`ifdef DUAL_RAM_RD_PARITY_EN
  output logic          o_tpar,
`endif
  output logic [DW-1:0] o_tdata,
  output logic          o_tvalid,
  input  logic          i_tready,
  output logic          o_tlast
);

  localparam int DEPTH = fifo_depth(RD_LAT);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int OW    = 4;
`ifdef DUAL_RAM_RD_PARITY_EN
  localparam int FW    = DW + 1;
`else
  localparam int FW    = DW;
`endif

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("RD_LAT out of range");
  end

  rd_state_t     state_q, state_d;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] addr_q;
  logic [AW:0]   len_q;
  logic [AW:0]   iss_cnt_q;
  logic [AW:0]   beat_q;
  logic [AW:0]   len_m1;
  logic          iss_q;
  logic [RD_LAT-1:0] sr_q;
  logic          done_q;

  logic          accept;
  logic          issue;
  logic          pop;
  logic          hs_last;
  logic [OW-1:0] occ;
  logic [CW-1:0] fifo_cnt;
  logic [FW-1:0] fifo_wdata;
  logic [FW-1:0] fifo_head;

  assign len_m1  = len_q - (AW+1)'(1);
  assign accept  = (state_q == IDLE) && i_start
                && (i_len != '0);
  assign pop     = o_tvalid && i_tready;
  assign hs_last = pop && (beat_q == len_m1);

  // Slots promised so far: address on the bus, RAM pipe, FIFO.
  always_comb begin
    occ = OW'(fifo_cnt) + OW'(iss_q);
    for (int i = 0; i < RD_LAT; i++) begin
      occ = occ + OW'(sr_q[i]);
    end
  end

  // A beat leaving this cycle frees its slot for the new read.
  assign issue = (state_q == READ)
              && ((occ - OW'(pop)) < OW'(DEPTH));

  // Next-state logic for the command sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = READ;
      end
      READ: begin
        if (issue && (iss_cnt_q == len_m1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (hs_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, address issue, read-tag pipe and beat counting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      iss_cnt_q <= '0;
      beat_q    <= '0;
      iss_q     <= 1'b0;
      sr_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      iss_q   <= issue;
      sr_q[0] <= iss_q;
      for (int i = 1; i < RD_LAT; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
      done_q  <= (state_q == DRAIN) && hs_last;
      if (accept) begin
        ptr_q     <= i_base_addr;
        len_q     <= i_len;
        iss_cnt_q <= '0;
        beat_q    <= '0;
      end
      if (issue) begin
        addr_q    <= ptr_q;
        ptr_q     <= ptr_q + AW'(1);
        iss_cnt_q <= iss_cnt_q + (AW+1)'(1);
      end
      if (pop) begin
        beat_q <= beat_q + (AW+1)'(1);
      end
    end
  end

`ifdef DUAL_RAM_RD_PARITY_EN
  assign fifo_wdata = {^i_rddata_b, i_rddata_b};
  assign o_tpar     = fifo_head[DW];
`else
  assign fifo_wdata = i_rddata_b;
`endif

  dual_ram_rd_fifo #(
    .W     (FW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .wr_en_i   (sr_q[RD_LAT-1]),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .valid_o   (o_tvalid),
    .count_o   (fifo_cnt)
  );

  assign o_tdata    = fifo_head[DW-1:0];
  assign o_tlast    = o_tvalid && (beat_q == len_m1);
  assign o_busy     = (state_q != IDLE);
  assign o_done     = done_q;
  assign o_addr_b   = addr_q;
  assign o_wr_en_b  = 1'b0;
  assign o_wrdata_b = '0;

endmodule

// File: tb/tb_dual_ram_rd_stream.sv
// Directed bench for dual_ram_rd_stream with a behavioural port-B RAM.
// Parity checks are included when DUAL_RAM_RD_PARITY_EN is defined.
module tb_dual_ram_rd_stream;

  localparam int AW     = 5;
  localparam int DW     = 16;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = RD_LAT + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   len;
  logic          busy, done;
  logic [AW-1:0] addr_b;
  logic          wr_en_b;
  logic [DW-1:0] wrdata_b;
  logic [DW-1:0] rddata_b;
  logic [DW-1:0] tdata;
  logic          tvalid, tready, tlast;
`ifdef DUAL_RAM_RD_PARITY_EN
  logic          tpar;
`endif

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] pipe [RD_LAT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dual_ram_rd_stream #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_base_addr (base),
    .i_len       (len),
    .o_busy      (busy),
    .o_done      (done),
    .o_addr_b    (addr_b),
    .o_wr_en_b   (wr_en_b),
    .o_wrdata_b  (wrdata_b),
    .i_rddata_b  (rddata_b),
`ifdef DUAL_RAM_RD_PARITY_EN
    .o_tpar      (tpar),
`endif
    .o_tdata     (tdata),
    .o_tvalid    (tvalid),
    .i_tready    (tready),
    .o_tlast     (tlast)
  );

  always @(posedge clk) begin
    pipe[0] <= mem[addr_b];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign rddata_b = pipe[RD_LAT-1];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, " tvalid"}, 32'(tvalid), 0);
    chk({tag, " tlast"}, 32'(tlast), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " addr"}, 32'(addr_b), 0);
    chk({tag, " tdata"}, 32'(tdata), 0);
    chk({tag, " wr_en"}, 32'(wr_en_b), 0);
    chk({tag, " wrdata"}, 32'(wrdata_b), 0);
`ifdef DUAL_RAM_RD_PARITY_EN
    chk({tag, " tpar"}, 32'(tpar), 0);
`endif
  endtask

  // Runs one command; rnd = random ready, inj = start pulse while busy.
  task automatic run_cmd(input logic [AW-1:0] b,
                         input logic [AW:0] n,
                         input bit rnd,
                         input bit inj,
                         input bit chk_lat);
    int k = 0;
    int cyc = -1;
    int first = -1;
    bit fin = 0;
    bit last_hs = 0;
    bit prev_stall = 0;
    logic [DW-1:0] prev_d = '0;
    logic [AW-1:0] a;
    logic [DW-1:0] e;
    start = 1'b1; base = b; len = n;
    tready = 1'b1;
    while (!fin && cyc < 400) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      start = 1'b0;
      if (inj && cyc == 1) begin
        start = 1'b1; base = b + 5'd9; len = 6'd2;
      end
      if (last_hs) begin
        chk("done pulse", 32'(done), 1);
        chk("busy low", 32'(busy), 0);
        chk("tvalid after", 32'(tvalid), 0);
        fin = 1;
      end else begin
        tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        chk("occ bound", 32'(dut.occ <= 4'(DEPTH)), 1);
        chk("no wr_en", 32'(wr_en_b), 0);
        chk("done early", 32'(done), 0);
        if (prev_stall) begin
          chk("stall valid", 32'(tvalid), 1);
          chk("stall data", 32'(tdata), 32'(prev_d));
        end
        if (tvalid && first < 0) first = cyc;
        if (!rnd && first >= 0)
          chk("no bubble", 32'(tvalid), 1);
        if (tvalid) begin
          a = b + AW'(k);
          e = mem[a];
          chk("tdata", 32'(tdata), 32'(e));
          chk("tlast", 32'(tlast), 32'(k == int'(n) - 1));
`ifdef DUAL_RAM_RD_PARITY_EN
          chk("tpar", 32'(tpar), 32'(^e));
`endif
          if (tready) begin
            k++;
            if (k == int'(n)) last_hs = 1;
          end
        end else begin
          chk("tlast idle", 32'(tlast), 0);
        end
        prev_stall = tvalid && !tready;
        prev_d = tdata;
      end
    end
    chk("cmd finished", 32'(fin), 1);
    chk("beats", 32'(k), 32'(n));
    if (chk_lat) chk("first lat", 32'(first), RD_LAT + 2);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("done one cycle", 32'(done), 0);
    chk("busy stays low", 32'(busy), 0);
  endtask

  initial begin
    logic [AW-1:0] hold;
    int seen;
    for (int i = 0; i < 2**AW; i++) mem[i] = DW'(i * 3);
    rst_n = 1'b0; start = 1'b0; base = '0;
    len = '0; tready = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd(5'd0, 6'd8, 0, 0, 1);
    run_cmd(5'd30, 6'd4, 0, 1, 1);
    run_cmd(5'd3, 6'd16, 1, 0, 0);

    hold = addr_b;
    start = 1'b1; base = 5'd12; len = 6'd0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("len0 busy", 32'(busy), 0);
      chk("len0 valid", 32'(tvalid), 0);
      chk("len0 done", 32'(done), 0);
      chk("len0 addr", 32'(addr_b), 32'(hold));
      @(posedge clk); @(negedge clk);
    end

    run_cmd(5'd7, 6'd32, 0, 0, 1);

    start = 1'b1; base = 5'd4; len = 6'd16;
    tready = 1'b1;
    seen = 0;
    for (int c = 0; c < 60 && seen < 5; c++) begin
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      if (tvalid) seen++;
    end
    chk("pre-abort beats", 32'(seen), 5);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk_idle_outs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("abort no done", 32'(done), 0);
      chk("abort idle", 32'(busy), 0);
    end
    run_cmd(5'd20, 6'd5, 0, 0, 1);

`ifdef DUAL_RAM_RD_PARITY_EN
    mem[10] = 16'h0007;
    mem[11] = 16'h0003;
    run_cmd(5'd10, 6'd2, 0, 0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
